// File: rtl/decodificador_display.sv
// ============================================================================
// decodificador_display
// ----------------------------------------------------------------------------
// Segment-data stage for a 4-digit 7-segment display. A binary value (credit
// or price) is accepted over a valid/ready handshake and converted to four BCD
// digits with an iterative shift-add-3 (double dabble), one bit per cycle. The
// finished digits are committed to a digit bank in a single cycle, so the
// display never shows a half-converted number. Values above 9999 put all four
// digits into dash mode and raise overflow.
//
// Ports
//   clk          in   1      system clock, all state on posedge
//   rst_n        in   1      asynchronous active-low reset
//   valor        in   WIDTH  binary value to display (hold until accepted)
//   valor_valid  in   1      valor is valid
//   valor_ready  out  1      block is idle and can accept a value
//   displays     in   4      one-hot anode select from the multiplexer, bit0 = units
//   segmentos    out  7      segment pattern {g,f,e,d,c,b,a}
//   overflow     out  1      committed value was above 9999 (dash mode)
//   busy         out  1      conversion in progress (inverse of valor_ready)
// ============================================================================
module decodificador_display #(
    parameter int WIDTH          = 14,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LEADING  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] valor,
    input  logic             valor_valid,
    output logic             valor_ready,
    input  logic [3:0]       displays,
    output logic [6:0]       segmentos,
    output logic             overflow,
    output logic             busy
);

    localparam int SR_W  = 16 + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        LOAD
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [SR_W-1:0]   shift_reg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              dash_pend;
    logic [15:0]       bank;
    logic [15:0]       bcd_adj;
    logic              accept;
    logic              too_big;
    logic [3:0]        nz_from;
    logic              sel_valid;
    logic [1:0]        sel_idx;
    logic [3:0]        digit;
    logic [6:0]        pattern;

    // Active-high gfedcba pattern for one BCD digit.
    function automatic logic [6:0] digit_pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    assign valor_ready = (state == IDLE);
    assign busy        = ~valor_ready;
    assign accept      = valor_valid & valor_ready;
    assign too_big     = 32'(valor) > 32'd9999;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Out-of-range values skip conversion and go straight to the commit cycle.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (accept) next_state = too_big ? LOAD : CONVERT;
            CONVERT: if (bit_cnt == LAST_BIT) next_state = LOAD;
            LOAD:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Add-3 correction on every BCD nibble that is 5 or more, applied before
    // the shift so the nibble carries correctly into the next decade.
    always_comb begin
        bcd_adj = shift_reg[SR_W-1:WIDTH];
        for (int i = 0; i < 4; i++) begin
            if (bcd_adj[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion datapath and digit bank. The bank only changes in LOAD, so
    // the previous value stays on the display for the whole conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            dash_pend <= 1'b0;
            bank      <= '0;
            overflow  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg <= {16'b0, valor};
                        bit_cnt   <= '0;
                        dash_pend <= too_big;
                    end
                end
                CONVERT: begin
                    shift_reg <= {bcd_adj, shift_reg[WIDTH-1:0]} << 1;
                    bit_cnt   <= bit_cnt + CNT_W'(1);
                end
                LOAD: begin
                    bank     <= dash_pend ? 16'h0000 : shift_reg[SR_W-1:WIDTH];
                    overflow <= dash_pend;
                end
                default: ;
            endcase
        end
    end

    // nz_from[i] is set when any digit from i up to the thousands is nonzero;
    // a clear bit means digit i is a leading zero.
    always_comb begin
        nz_from[3] = |bank[15:12];
        nz_from[2] = nz_from[3] | (|bank[11:8]);
        nz_from[1] = nz_from[2] | (|bank[7:4]);
        nz_from[0] = nz_from[1] | (|bank[3:0]);
    end

    // Segment output is purely combinational from the anode select and the
    // registered bank so it switches in step with the multiplexer.
    always_comb begin
        sel_valid = 1'b1;
        sel_idx   = 2'd0;
        case (displays)
            4'b0001: sel_idx = 2'd0;
            4'b0010: sel_idx = 2'd1;
            4'b0100: sel_idx = 2'd2;
            4'b1000: sel_idx = 2'd3;
            default: sel_valid = 1'b0;
        endcase
        digit   = bank[{sel_idx, 2'b00} +: 4];
        pattern = 7'h00;
        if (!sel_valid) begin
            pattern = 7'h00;
        end else if (overflow) begin
            pattern = 7'h40;
        end else if (BLANK_LEADING && (sel_idx != 2'd0) && !nz_from[sel_idx]) begin
            pattern = 7'h00;
        end else begin
            pattern = digit_pattern(digit);
        end
        segmentos = SEG_ACTIVE_LOW ? ~pattern : pattern;
    end

endmodule

// File: tb/tb_decodificador_display.sv
// ============================================================================
// tb_decodificador_display
// ----------------------------------------------------------------------------
// Self-checking bench for decodificador_display (WIDTH=14, active-low
// segments, leading blanking). A decimal model of the committed value and of
// the accept-to-commit timing predicts segmentos/ready/busy/overflow every
// cycle; hand-computed literal expectations pin the model.
// ============================================================================
module tb_decodificador_display;

    localparam int WIDTH = 14;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [WIDTH-1:0] valor;
    logic             valor_valid;
    logic             valor_ready;
    logic [3:0]       displays;
    logic [6:0]       segmentos;
    logic             overflow;
    logic             busy;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Literal expectation mailbox: posted by the stimulus, checked by the
    // compare process at the next falling edge.
    string lit_name = "";
    int    lit_act  = 0;
    int    lit_exp  = 0;
    int    lit_seq  = 0;
    int    lit_ack  = 0;

    // Model state: committed decimal value, dash flag and pending commit.
    int   model_val;
    logic model_dash;
    int   pend_cnt;
    int   pend_val;
    logic pend_dash;

    always #5 clk = ~clk;

    decodificador_display #(
        .WIDTH(WIDTH),
        .SEG_ACTIVE_LOW(1'b1),
        .BLANK_LEADING(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .valor(valor),
        .valor_valid(valor_valid),
        .valor_ready(valor_ready),
        .displays(displays),
        .segmentos(segmentos),
        .overflow(overflow),
        .busy(busy)
    );

    // Timing model: an accepted value commits WIDTH+1 edges later, an
    // out-of-range value one edge later; nothing is accepted meanwhile.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_val  <= 0;
            model_dash <= 1'b0;
            pend_cnt   <= 0;
            pend_val   <= 0;
            pend_dash  <= 1'b0;
        end else if (pend_cnt > 0) begin
            pend_cnt <= pend_cnt - 1;
            if (pend_cnt == 1) begin
                model_val  <= pend_val;
                model_dash <= pend_dash;
            end
        end else if (valor_valid) begin
            if (int'(valor) > 9999) begin
                pend_cnt  <= 1;
                pend_dash <= 1'b1;
                pend_val  <= 0;
            end else begin
                pend_cnt  <= WIDTH + 1;
                pend_dash <= 1'b0;
                pend_val  <= int'(valor);
            end
        end
    end

    function automatic logic [6:0] lit_pattern(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            default: return 7'h6F;
        endcase
    endfunction

    // Expected active-low segments from the decimal value and the anode select.
    function automatic logic [6:0] exp_seg(input int val, input logic dash, input logic [3:0] sel);
        int         idx;
        int         p;
        logic [6:0] pat;
        idx = 0;
        p   = 1;
        pat = 7'h00;
        if ($countones(sel) == 1) begin
            for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
            for (int i = 0; i < idx; i++) p = p * 10;
            if (dash) pat = 7'h40;
            else if (idx > 0 && val < p) pat = 7'h00;
            else pat = lit_pattern((val / p) % 10);
        end
        return ~pat;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        n_compared++;
        if (act != exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: model checks every cycle plus any posted literal.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("seg_model", int'(segmentos), int'(exp_seg(model_val, model_dash, displays)));
            checkOutput("ready_model", int'(valor_ready), (pend_cnt == 0) ? 1 : 0);
            checkOutput("busy_model", int'(busy), (pend_cnt != 0) ? 1 : 0);
            checkOutput("ovf_model", int'(overflow), int'(model_dash));
            if (lit_seq != lit_ack) begin
                checkOutput(lit_name, lit_act, lit_exp);
                lit_ack = lit_seq;
            end
        end
    end

    task automatic postLiteral(input string name, input int act, input int exp);
        lit_name = name;
        lit_act  = act;
        lit_exp  = exp;
        lit_seq++;
    endtask

    task automatic expectLiteral(input string name, input int act, input int exp);
        postLiteral(name, act, exp);
        @(negedge clk);
        #1;
    endtask

    task automatic showDigit(input string name, input logic [3:0] sel, input int exp);
        displays = sel;
        #1;
        expectLiteral(name, int'(segmentos), exp);
    endtask

    // Pulse one value and count how many falling edges ready stays low.
    task automatic applyStimulus(input int v, output int low);
        @(posedge clk);
        #1;
        valor       = WIDTH'(v);
        valor_valid = 1'b1;
        @(posedge clk);
        #1;
        valor_valid = 1'b0;
        low = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (valor_ready) break;
            low++;
            displays = 4'(4'b0001 << (i % 4));
        end
        #1;
    endtask

    initial begin
        int low;
        valor       = '0;
        valor_valid = 1'b0;
        displays    = 4'b0001;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;

        // Reset state
        expectLiteral("rst_ready", int'(valor_ready), 1);
        expectLiteral("rst_ovf", int'(overflow), 0);
        showDigit("rst_units", 4'b0001, 7'h40);
        showDigit("rst_thousands", 4'b1000, 7'h7F);
        showDigit("rst_two_hot", 4'b0011, 7'h7F);
        showDigit("rst_none", 4'b0000, 7'h7F);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1234
        applyStimulus(1234, low);
        expectLiteral("lat_1234", low, 15);
        showDigit("d0_1234", 4'b0001, 7'h19);
        showDigit("d1_1234", 4'b0010, 7'h30);
        showDigit("d2_1234", 4'b0100, 7'h24);
        showDigit("d3_1234", 4'b1000, 7'h79);

        // Leading blanking
        applyStimulus(7, low);
        showDigit("d0_7", 4'b0001, 7'h78);
        showDigit("d1_7", 4'b0010, 7'h7F);
        showDigit("d2_7", 4'b0100, 7'h7F);
        showDigit("d3_7", 4'b1000, 7'h7F);
        applyStimulus(1000, low);
        showDigit("d1_1000", 4'b0010, 7'h40);
        showDigit("d2_1000", 4'b0100, 7'h40);
        showDigit("d3_1000", 4'b1000, 7'h79);
        applyStimulus(9999 + 1, low);
        expectLiteral("lat_10000", low, 1);

        // Overflow and recovery
        applyStimulus(12000, low);
        expectLiteral("lat_12000", low, 1);
        expectLiteral("ovf_12000", int'(overflow), 1);
        for (int i = 0; i < 4; i++) begin
            showDigit("dash_digit", 4'(4'b0001 << i), 7'h3F);
        end
        applyStimulus(5, low);
        expectLiteral("ovf_clear", int'(overflow), 0);
        showDigit("d0_5", 4'b0001, 7'h12);

        // Valid while busy is ignored; bank holds 1234 until the 9999 commit
        applyStimulus(1234, low);
        displays = 4'b0001;
        @(posedge clk);
        #1;
        valor       = WIDTH'(9999);
        valor_valid = 1'b1;
        @(posedge clk);
        #1;
        valor_valid = 1'b0;
        low = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (valor_ready) break;
            low++;
            if (i == 3) begin
                valor       = WIDTH'(42);
                valor_valid = 1'b1;
            end
            if (i == 4) valor_valid = 1'b0;
            if (i == 12) begin
                #1 postLiteral("hold_1234", int'(segmentos), 7'h19);
            end
        end
        #1;
        expectLiteral("lat_9999", low, 15);
        for (int i = 0; i < 4; i++) begin
            showDigit("d_9999", 4'(4'b0001 << i), 7'h10);
        end
        repeat (20) @(negedge clk);
        #1 expectLiteral("no_42", int'(segmentos), 7'h10);

        // Reset mid-conversion aborts the 8888
        @(posedge clk);
        #1;
        valor       = WIDTH'(8888);
        valor_valid = 1'b1;
        @(posedge clk);
        #1;
        valor_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 expectLiteral("abort_ready", int'(valor_ready), 1);
        showDigit("abort_units", 4'b0001, 7'h40);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        showDigit("post_abort_units", 4'b0001, 7'h40);
        showDigit("post_abort_tens", 4'b0010, 7'h7F);
        expectLiteral("post_abort_ready", int'(valor_ready), 1);

        repeat (3) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
